// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, default latencies, widths.
// MDU_MADD_EN enables the multiply-accumulate opcodes (MADD/MADDU/MSUB/MSUBU) in decode.
package md_pkg;

    localparam int MD_DATA_W          = 32;
    localparam int MD_OP_W            = 4;
    localparam int MD_CNT_W           = 16;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    localparam logic [MD_OP_W-1:0] MD_NOP   = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd9;
    localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd10;
    localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd11;
    localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd12;

    typedef enum logic {
        MD_ST_IDLE = 1'b0,
        MD_ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the HI/LO resource for a multi-cycle latency.
    function automatic logic md_is_compute(input logic [MD_OP_W-1:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        logic r;
        case (op)
            MD_DIV, MD_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result.
// MDU_MADD_EN adds the accumulate paths that fold in the current hi/lo.
module md_calc
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0]   op,
    input  logic [MD_DATA_W-1:0] a,
    input  logic [MD_DATA_W-1:0] b,
    input  logic [MD_DATA_W-1:0] hi,
    input  logic [MD_DATA_W-1:0] lo,
    output logic [63:0]          result
);

    logic [63:0]          prod_signed_s;
    logic [63:0]          prod_unsigned_s;
    logic                 div_zero_s;
    logic                 div_ovf_s;
    logic signed [31:0]   dividend_s;
    logic signed [31:0]   divisor_s;
    logic signed [31:0]   quot_s;
    logic signed [31:0]   rem_s;
    logic [31:0]          udivisor_s;
    logic [31:0]          uquot_s;
    logic [31:0]          urem_s;

    assign prod_signed_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_unsigned_s = {32'd0, a} * {32'd0, b};

    assign div_zero_s = (b == 32'd0);
    assign div_ovf_s  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Guarded divisors keep the arithmetic defined; the special cases are muxed in below.
    assign dividend_s = a;
    assign divisor_s  = (div_zero_s || div_ovf_s) ? 32'sd1 : b;
    assign quot_s     = dividend_s / divisor_s;
    assign rem_s      = dividend_s % divisor_s;
    assign udivisor_s = div_zero_s ? 32'd1 : b;
    assign uquot_s    = a / udivisor_s;
    assign urem_s     = a % udivisor_s;

`ifndef MDU_MADD_EN
    logic unused_acc_s;
    assign unused_acc_s = ^{hi, lo};
`endif

    // Result select per opcode, with divide-by-zero and signed-overflow overrides.
    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_signed_s;
            MD_MULTU: result = prod_unsigned_s;
            MD_DIV: begin
                if (div_zero_s) begin
                    result = {a, 32'hFFFF_FFFF};
                end else if (div_ovf_s) begin
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    result = {rem_s, quot_s};
                end
            end
            MD_DIVU: begin
                if (div_zero_s) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {urem_s, uquot_s};
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_signed_s;
            MD_MADDU: result = {hi, lo} + prod_unsigned_s;
            MD_MSUB:  result = {hi, lo} - prod_signed_s;
            MD_MSUBU: result = {hi, lo} - prod_unsigned_s;
`endif
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, pending result, commit to hi/lo.
// MDU_MADD_EN enables the multiply-accumulate opcodes (decoded in md_pkg, computed in md_calc).
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MD_OP_W-1:0]   op,
    input  logic [MD_DATA_W-1:0] a,
    input  logic [MD_DATA_W-1:0] b,
    input  logic                 flush,
    output logic [MD_DATA_W-1:0] hi,
    output logic [MD_DATA_W-1:0] lo,
    output logic [MD_DATA_W-1:0] rd_data,
    output logic                 busy,
    output logic                 md_stall
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
    localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

    md_state_e              state_r;
    logic [MD_CNT_W-1:0]    cnt_r;
    logic [MD_DATA_W-1:0]   pend_hi_r;
    logic [MD_DATA_W-1:0]   pend_lo_r;
    logic [MD_DATA_W-1:0]   hi_r;
    logic [MD_DATA_W-1:0]   lo_r;
    logic                   busy_r;
    logic                   start_s;
    logic [63:0]            calc_s;

    md_calc u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi_r),
        .lo     (lo_r),
        .result (calc_s)
    );

    assign start_s  = md_is_compute(op) & ~busy_r & ~flush;
    assign md_stall = busy_r | start_s;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;

    // Read port for mfhi/mflo; returns the committed registers even mid-operation.
    always_comb begin
        rd_data = 32'd0;
        case (op)
            MD_MFHI: rd_data = hi_r;
            MD_MFLO: rd_data = lo_r;
            default: rd_data = 32'd0;
        endcase
    end

    // Sequencer: start latches the result, RUN counts down, count 1 commits to hi/lo.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= MD_ST_IDLE;
            cnt_r     <= '0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                MD_ST_IDLE: begin
                    if (start_s) begin
                        state_r   <= MD_ST_RUN;
                        cnt_r     <= md_is_div(op) ? DIV_LOAD : MULT_LOAD;
                        pend_hi_r <= calc_s[63:32];
                        pend_lo_r <= calc_s[31:0];
                        busy_r    <= 1'b1;
                    end else if (!flush && op == MD_MTHI) begin
                        hi_r <= a;
                    end else if (!flush && op == MD_MTLO) begin
                        lo_r <= a;
                    end
                end
                MD_ST_RUN: begin
                    if (cnt_r == CNT_ONE) begin
                        state_r <= MD_ST_IDLE;
                        cnt_r   <= '0;
                        hi_r    <= pend_hi_r;
                        lo_r    <= pend_lo_r;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= MD_ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; the accumulate check follows MDU_MADD_EN.
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        busy;
    logic        md_stall;

    int n_assert = 0;
    int n_fail   = 0;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data),
        .busy     (busy),
        .md_stall (md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a compute op, ride out its busy window, then check busy drop and committed hi/lo.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        op = o; a = av; b = bv;
        #1;
        chk({tag, " stall@start"}, {31'd0, md_stall}, 32'd1);
        chk({tag, " busy@start"}, {31'd0, busy}, 32'd0);
        tick();
        op = MD_NOP;
        #1;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " stall"}, {31'd0, md_stall}, 32'd1);
            tick();
        end
        chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; op = MD_NOP; a = 32'd0; b = 32'd0; flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset stall", {31'd0, md_stall}, 32'd0);
        chk("reset rd_data", rd_data, 32'd0);

        run_op("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        op = MD_MFLO;
        #1;
        chk("mflo after mult", rd_data, 32'hFFFF_FFFA);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 5/0", MD_DIVU, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
        run_op("div -5/0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
        run_op("divu big", MD_DIVU, 32'hFFFF_FFFF, 32'd16, 10, 32'd15, 32'h0FFF_FFFF);
        run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // mthi/mtlo with and without flush, and the read port
        op = MD_MTHI; a = 32'h1234; flush = 1'b1;
        #1;
        chk("mthi flushed stall", {31'd0, md_stall}, 32'd0);
        tick();
        op = MD_NOP; flush = 1'b0;
        #1;
        chk("mthi flushed hi", hi, 32'd0);
        op = MD_MTHI; a = 32'h1234;
        tick();
        op = MD_MFHI;
        #1;
        chk("mthi hi", hi, 32'h1234);
        chk("mfhi rd_data", rd_data, 32'h1234);
        op = MD_MTLO; a = 32'h5678;
        tick();
        op = MD_MFLO;
        #1;
        chk("mflo rd_data", rd_data, 32'h5678);
        op = MD_NOP;
        #1;
        chk("nop rd_data", rd_data, 32'd0);

        // flushed start and reserved opcode never start
        op = MD_MULT; a = 32'd2; b = 32'd3; flush = 1'b1;
        #1;
        chk("flushed start stall", {31'd0, md_stall}, 32'd0);
        tick();
        op = 4'd13; flush = 1'b0;
        #1;
        chk("flushed start busy", {31'd0, busy}, 32'd0);
        chk("flushed start hi", hi, 32'h1234);
        chk("op13 stall", {31'd0, md_stall}, 32'd0);
        tick();
        chk("op13 busy", {31'd0, busy}, 32'd0);

        // DIV presented mid-busy is ignored, then accepted the cycle busy falls
        op = MD_MULTU; a = 32'd6; b = 32'd7;
        #1;
        chk("ovl start stall", {31'd0, md_stall}, 32'd1);
        tick();
        op = MD_NOP;
        #1;
        chk("ovl busy c1", {31'd0, busy}, 32'd1);
        tick();
        chk("ovl busy c2", {31'd0, busy}, 32'd1);
        tick();
        op = MD_DIV; a = 32'd100; b = 32'd7;
        #1;
        for (int i = 3; i <= 5; i++) begin
            chk("ovl busy c3-5", {31'd0, busy}, 32'd1);
            chk("ovl stall c3-5", {31'd0, md_stall}, 32'd1);
            tick();
        end
        chk("ovl busy falls", {31'd0, busy}, 32'd0);
        chk("ovl multu hi", hi, 32'd0);
        chk("ovl multu lo", lo, 32'd42);
        chk("ovl div accept stall", {31'd0, md_stall}, 32'd1);
        tick();
        op = MD_NOP;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("ovl div busy", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("ovl div done", {31'd0, busy}, 32'd0);
        chk("ovl div hi", hi, 32'd2);
        chk("ovl div lo", lo, 32'd14);

        // reset in cycle 4 of a DIV aborts it
        op = MD_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
        tick();
        op = MD_NOP;
        for (int i = 1; i <= 3; i++) begin
            chk("rst-div busy", {31'd0, busy}, 32'd1);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst-div hi", hi, 32'd0);
        chk("rst-div lo", lo, 32'd0);
        chk("rst-div busy", {31'd0, busy}, 32'd0);
        chk("rst-div stall", {31'd0, md_stall}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("rst-div no commit hi", hi, 32'd0);
        chk("rst-div no commit lo", lo, 32'd0);
        chk("rst-div idle", {31'd0, busy}, 32'd0);

        // accumulate: hi=0, lo=all ones, then MADDU 1*1
        op = MD_MTLO; a = 32'hFFFF_FFFF;
        tick();
`ifdef MDU_MADD_EN
        run_op("maddu", MD_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        op = MD_MADDU; a = 32'd1; b = 32'd1;
        #1;
        chk("maddu off stall", {31'd0, md_stall}, 32'd0);
        tick();
        op = MD_NOP;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("maddu off busy", {31'd0, busy}, 32'd0);
            tick();
        end
        chk("maddu off hi", hi, 32'd0);
        chk("maddu off lo", lo, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
